// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the decode-to-execute control record.
// Imported by the decode stage and its register file.
package y86_pkg;

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_RRMOV = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSHQ = 4'hA;
  localparam logic [3:0] I_POPQ  = 4'hB;

  localparam logic [2:0] S_BUB = 3'd0;
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  // Width-independent fields of the E pipeline register; data words live beside it.
  typedef struct packed {
    logic [2:0] stat;
    logic [3:0] icode;
    logic [3:0] ifun;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
    logic [3:0] src_a;
    logic [3:0] src_b;
  } e_ctl_t;

  localparam e_ctl_t E_CTL_BUBBLE = '{
    stat: S_BUB, icode: I_NOP, ifun: 4'h0,
    dst_e: RNONE, dst_m: RNONE, src_a: RNONE, src_b: RNONE
  };

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 register file: two combinational reads, two synchronous writes.
// The M port wins a same-ID conflict; IDs at or above NREGS read 0 and never write.
module y86_regfile
  import y86_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      i_src_a,
  input  logic [3:0]      i_src_b,
  input  logic [3:0]      i_dst_e,
  input  logic [XLEN-1:0] i_val_e,
  input  logic [3:0]      i_dst_m,
  input  logic [XLEN-1:0] i_val_m,
  output logic [XLEN-1:0] o_val_a,
  output logic [XLEN-1:0] o_val_b
);

  logic [XLEN-1:0] r_regs [NREGS];

  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    // NOTE: architectural registers are few and must read 0 after reset, so each one is reset explicitly.
    always_ff @(posedge clk) begin
      if (reset)                      r_regs[g] <= '0;
      else if (i_dst_m == 4'(g))      r_regs[g] <= i_val_m;
      else if (i_dst_e == 4'(g))      r_regs[g] <= i_val_e;
    end
  end

  // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
  always_comb begin
    o_val_a = '0;
    o_val_b = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (i_src_a == 4'(i)) o_val_a = r_regs[i];
      if (i_src_b == 4'(i)) o_val_b = r_regs[i];
    end
  end

endmodule

// File: rtl/pipe_decode_rf.sv
// Y86-64 decode/write-back stage: register IDs, forwarded operands,
// load-use detection and the D-to-E pipeline register.
module pipe_decode_rf
  import y86_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int NREGS  = 15,
  parameter int RID_W  = 4,
  parameter int RSP_ID = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       D_stat,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       D_ifun,
  input  logic [RID_W-1:0] D_rA,
  input  logic [RID_W-1:0] D_rB,
  input  logic [XLEN-1:0]  D_valC,
  input  logic [XLEN-1:0]  D_valP,
  input  logic             E_stall,
  input  logic             E_bubble,
  input  logic [RID_W-1:0] e_dstE,
  input  logic [XLEN-1:0]  e_valE,
  input  logic [RID_W-1:0] M_dstE,
  input  logic [XLEN-1:0]  M_valE,
  input  logic [RID_W-1:0] M_dstM,
  input  logic [XLEN-1:0]  m_valM,
  input  logic [RID_W-1:0] W_dstE,
  input  logic [XLEN-1:0]  W_valE,
  input  logic [RID_W-1:0] W_dstM,
  input  logic [XLEN-1:0]  W_valM,
  output logic [RID_W-1:0] d_srcA,
  output logic [RID_W-1:0] d_srcB,
  output logic             load_use,
  output logic [2:0]       E_stat,
  output logic [3:0]       E_icode,
  output logic [3:0]       E_ifun,
  output logic [XLEN-1:0]  E_valC,
  output logic [XLEN-1:0]  E_valA,
  output logic [XLEN-1:0]  E_valB,
  output logic [RID_W-1:0] E_dstE,
  output logic [RID_W-1:0] E_dstM,
  output logic [RID_W-1:0] E_srcA,
  output logic [RID_W-1:0] E_srcB
);

  localparam logic [RID_W-1:0] RSP = RID_W'(RSP_ID);

  logic [RID_W-1:0] w_src_a, w_src_b, w_dst_e, w_dst_m;
  logic [XLEN-1:0]  w_rf_a, w_rf_b, w_val_a, w_val_b;

  e_ctl_t          r_ctl;
  logic [XLEN-1:0] r_val_c, r_val_a, r_val_b;

  always_comb begin
    w_src_a = RNONE;
    w_src_b = RNONE;
    w_dst_e = RNONE;
    w_dst_m = RNONE;
    case (D_icode)
      I_RRMOV: begin w_src_a = D_rA; w_dst_e = D_rB; end
      I_IRMOV: w_dst_e = D_rB;
      I_RMMOV: begin w_src_a = D_rA; w_src_b = D_rB; end
      I_MRMOV: begin w_src_b = D_rB; w_dst_m = D_rA; end
      I_OPQ:   begin w_src_a = D_rA; w_src_b = D_rB; w_dst_e = D_rB; end
      I_CALL:  begin w_src_b = RSP;  w_dst_e = RSP; end
      I_RET:   begin w_src_a = RSP;  w_src_b = RSP; w_dst_e = RSP; end
      I_PUSHQ: begin w_src_a = D_rA; w_src_b = RSP; w_dst_e = RSP; end
      I_POPQ:  begin w_src_a = RSP;  w_src_b = RSP; w_dst_e = RSP; w_dst_m = D_rA; end
      default: ;
    endcase
  end

  y86_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk     (clk),
    .reset   (reset),
    .i_src_a (w_src_a),
    .i_src_b (w_src_b),
    .i_dst_e (W_dstE),
    .i_val_e (W_valE),
    .i_dst_m (W_dstM),
    .i_val_m (W_valM),
    .o_val_a (w_rf_a),
    .o_val_b (w_rf_b)
  );

  // Youngest producer wins; an RNONE source never matches and yields 0.
  function automatic logic [XLEN-1:0] fwd(input logic [RID_W-1:0] src,
                                          input logic [XLEN-1:0]  rf);
    if (src == RNONE)       return '0;
    else if (src == e_dstE) return e_valE;
    else if (src == M_dstM) return m_valM;
    else if (src == M_dstE) return M_valE;
    else if (src == W_dstM) return W_valM;
    else if (src == W_dstE) return W_valE;
    else                    return rf;
  endfunction

  always_comb begin
    w_val_a = (D_icode == I_JXX || D_icode == I_CALL) ? D_valP : fwd(w_src_a, w_rf_a);
    w_val_b = fwd(w_src_b, w_rf_b);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctl   <= E_CTL_BUBBLE;
      r_val_c <= '0;
      r_val_a <= '0;
      r_val_b <= '0;
    end else if (!E_stall) begin
      if (E_bubble) begin
        r_ctl   <= E_CTL_BUBBLE;
        r_val_c <= '0;
        r_val_a <= '0;
        r_val_b <= '0;
      end else begin
        r_ctl   <= '{stat: D_stat, icode: D_icode, ifun: D_ifun,
                     dst_e: w_dst_e, dst_m: w_dst_m, src_a: w_src_a, src_b: w_src_b};
        r_val_c <= D_valC;
        r_val_a <= w_val_a;
        r_val_b <= w_val_b;
      end
    end
  end

  assign d_srcA  = w_src_a;
  assign d_srcB  = w_src_b;
  assign E_stat  = r_ctl.stat;
  assign E_icode = r_ctl.icode;
  assign E_ifun  = r_ctl.ifun;
  assign E_dstE  = r_ctl.dst_e;
  assign E_dstM  = r_ctl.dst_m;
  assign E_srcA  = r_ctl.src_a;
  assign E_srcB  = r_ctl.src_b;
  assign E_valC  = r_val_c;
  assign E_valA  = r_val_a;
  assign E_valB  = r_val_b;

  assign load_use = (r_ctl.icode == I_MRMOV || r_ctl.icode == I_POPQ) &&
                    (r_ctl.dst_m != RNONE) &&
                    (r_ctl.dst_m == w_src_a || r_ctl.dst_m == w_src_b);

endmodule

// File: doc/pipe_decode_rf.md
Name: pipe_decode_rf

Overview:
- Decode/write-back stage for the pipelined Y86-64 core.
- Holds the register file and generates srcA/srcB/dstE/dstM from icode/rA/rB.
- Selects valA/valB with full forwarding from the E, M and W stages, and detects load-use hazards.
- Owns the D→E pipeline register, with stall and bubble control; parametrised in data width and register count.

Parameters:
- XLEN, 64, data/register width in bits
- NREGS, 15, implemented architectural registers (IDs 0..NREGS-1, max 15)
- RID_W, 4, register-ID width; ID 4'hF = RNONE
- RSP_ID, 4, stack-pointer register ID

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- D_stat  in  3  fetch status (BUB=0, AOK=1, HLT=2, ADR=3, INS=4)
- D_icode  in  4  instruction code
- D_ifun  in  4  function code
- D_rA  in  4  register-A field
- D_rB  in  4  register-B field
- D_valC  in  XLEN  constant word
- D_valP  in  XLEN  incremented PC
- E_stall  in  1  hold E register
- E_bubble  in  1  load nop into E register
- e_dstE  in  4  execute-stage destination (post-cmov)
- e_valE  in  XLEN  ALU result
- M_dstE  in  4  memory-stage dstE
- M_valE  in  XLEN  memory-stage valE
- M_dstM  in  4  memory-stage dstM
- m_valM  in  XLEN  memory read data
- W_dstE  in  4  write-back dstE; write port E
- W_valE  in  XLEN  write-back valE
- W_dstM  in  4  write-back dstM; write port M
- W_valM  in  XLEN  write-back valM
- d_srcA  out  4  combinational srcA (to hazard control)
- d_srcB  out  4  combinational srcB
- load_use  out  1  combinational load-use hazard flag
- E_stat  out  3  registered status
- E_icode  out  4  registered icode
- E_ifun  out  4  registered ifun
- E_valC  out  XLEN  registered valC
- E_valA  out  XLEN  registered valA
- E_valB  out  XLEN  registered valB
- E_dstE  out  4  registered dstE
- E_dstM  out  4  registered dstM
- E_srcA  out  4  registered srcA
- E_srcB  out  4  registered srcB

Behaviour:
- icode map: 0 halt, 1 nop, 2 rrmov/cmov, 3 irmov, 4 rmmov, 5 mrmov, 6 OPq, 7 jXX, 8 call, 9 ret, A push, B pop; any other value acts as nop for decode.
- srcA: rA for {2,4,6,A}; RSP_ID for {9,B}; else RNONE.
- srcB: rB for {4,5,6}; RSP_ID for {8,9,A,B}; else RNONE.
- dstE: rB for {2,3,6}; RSP_ID for {8,9,A,B}; else RNONE.
- dstM: rA for {5,B}; else RNONE.
- valA: D_valP for icode {7,8}. Otherwise priority forwarding on srcA:
  - e_dstE→e_valE
  - M_dstM→m_valM
  - M_dstE→M_valE
  - W_dstM→W_valM
  - W_dstE→W_valE
  - else register file read.
- valB: same chain keyed on srcB, without the valP case.
- A source equal to RNONE never matches; it yields 0.
- Register file: 2 combinational read ports, 2 synchronous write ports (W_dstE, W_dstM); RNONE means no write.
- Same-ID write conflict: the M port wins (popq %rsp semantics).
- IDs ≥ NREGS: reads return 0; writes ignored.
- Same-cycle read-after-write is covered by W forwarding; the register file does not bypass internally.
- load_use = (E_icode ∈ {5,B}) && E_dstM≠RNONE && (E_dstM==d_srcA || E_dstM==d_srcB).
- E register update, in priority order:
  - reset → bubble state
  - E_stall → hold; stall beats a simultaneous bubble
  - E_bubble → bubble state
  - else load decoded values.
- Bubble state: stat=BUB, icode=1, ifun=0, valC/valA/valB=0, all IDs=RNONE.
- Reset also clears all NREGS registers to 0; a reset mid-operation discards any in-flight W writes that same edge.
- Latency: 1 cycle from D inputs to E outputs.

Decomposition:
- Package y86_pkg holds:
  - icode constants (I_HALT..I_POPQ)
  - stat constants (S_BUB, S_AOK, S_HLT, S_ADR, S_INS)
  - RNONE
  - the E-register field struct.
- Sub-module y86_regfile (param XLEN, NREGS): 2R/2W, M-port priority, synchronous reset clear.

Test Plan:
- Reset → all E outputs in bubble state (icode=1, IDs=F); regfile reads 0.
- Write W_dstE=3, W_valE=0x1234, then decode OPq rA=3 rB=3 → E_valA=E_valB=0x1234, E_dstE=3.
- Forwarding priority:
  - e_dstE=2/e_valE=0xAA with M_dstE=2/M_valE=0xBB, decode rrmov rA=2 → E_valA=0xAA
  - drop e_dstE → 0xBB.
- Conflict: W_dstE=W_dstM=4 with valE=1, valM=2 → reg4=2. Then E_icode=5, E_dstM=6 and decode OPq rA=6 → load_use=1.
- Stall and bubble: E_stall=1 with E_bubble=1 → E holds prior values; E_bubble alone → stat=BUB, icode=1.
- call with D_valP=0x40 → E_valA=0x40, srcB=dstE=4, dstM=F.
- NREGS=8 build: write ID 9 ignored, read ID 9 returns 0.
